// File: rtl/pixmode_pkg.sv
// Shared definitions for the pixmode_seq frame-synchronous mode sequencer:
// mode codes, FSM state encoding and the mode legalisation helper.
package pixmode_pkg;

  localparam logic [1:0] MODE_RGB = 2'd0;
  localparam logic [1:0] MODE_Y   = 2'd1;
  localparam logic [1:0] MODE_U   = 2'd2;
  localparam logic [1:0] MODE_V   = 2'd3;

  typedef enum logic [1:0] {
    MAN_IDLE = 2'd0,
    MAN_PEND = 2'd1,
    AUTO     = 2'd2
  } state_e;

  // Out-of-range switch settings fall back to RGB.
  function automatic logic [1:0] legalize(input logic [7:0] x);
    logic [1:0] r;
    if (x <= 8'd3) begin
      r = x[1:0];
    end else begin
      r = MODE_RGB;
    end
    return r;
  endfunction

endpackage

// File: rtl/pixmode_seq_btn_debounce.sv
// Push-button debouncer: a level is accepted after DB_CYCLES consecutive
// cycles of disagreement with the current debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  output logic db_o,
  output logic rise_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;

  // Any cycle that agrees with the accepted level restarts the stability window.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    if (lvl_i == db_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = {CW{1'b0}};
      db_d   = lvl_i;
      rise_d = lvl_i;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/pixmode_seq.sv
// Frame-synchronous pixel mode sequencer; requested modes apply only at a
// vsync rising edge. Define PIXMODE_AUTO_EN to build the auto-cycle state.
module pixmode_seq
  import pixmode_pkg::*;
#(
  parameter int DB_CYCLES       = 50000,
  parameter int FRAMES_PER_MODE = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_c,
  input  logic [7:0] sw_mode,
  input  logic       btn_next,
  input  logic       sw_auto,
  output logic [7:0] out_swt,
  output logic [1:0] out_mode,
  output logic       out_pend
);

  logic [7:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic       btn_s1_q, btn_s2_q;
  logic       vs_q;
  logic       btn_db, btn_rise;
  logic       sw_evt, vs_rise, req;
  logic [1:0] req_tgt;
  logic       unused_s;

  state_e     state_q, state_d;
  logic [1:0] tgt_q, tgt_d;
  logic [1:0] mode_q, mode_d;
  logic       pend_q, pend_d;

`ifdef PIXMODE_AUTO_EN
  localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_MODE - 1);
  logic       auto_s1_q, auto_s2_q;
  logic [7:0] fcnt_q, fcnt_d;
  assign unused_s = ^{in_c[1:0], btn_db};
`else
  assign unused_s = ^{in_c[1:0], btn_db, sw_auto, 8'(FRAMES_PER_MODE)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= 8'd0;
      sw_s2_q   <= 8'd0;
      sw_prev_q <= 8'd0;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      vs_q      <= 1'b0;
`ifdef PIXMODE_AUTO_EN
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
`endif
    end else begin
      sw_s1_q   <= sw_mode;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
      btn_s1_q  <= btn_next;
      btn_s2_q  <= btn_s1_q;
      vs_q      <= in_c[2];
`ifdef PIXMODE_AUTO_EN
      auto_s1_q <= sw_auto;
      auto_s2_q <= auto_s1_q;
`endif
    end
  end

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .lvl_i (btn_s2_q),
    .db_o  (btn_db),
    .rise_o(btn_rise)
  );

  // A switch event outranks a press arriving in the same cycle.
  assign sw_evt  = (sw_s2_q != sw_prev_q);
  assign vs_rise = in_c[2] & ~vs_q;
  assign req     = sw_evt | btn_rise;
  assign req_tgt = sw_evt ? legalize(sw_s2_q) : (mode_q + 2'd1);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
`ifdef PIXMODE_AUTO_EN
    fcnt_d  = fcnt_q;
`endif
    case (state_q)
      MAN_IDLE: begin
        if (req) begin
          tgt_d   = req_tgt;
          state_d = MAN_PEND;
        end else begin
          state_d = MAN_IDLE;
        end
      end
      MAN_PEND: begin
        if (vs_rise) begin
          mode_d = tgt_q;
        end else begin
          mode_d = mode_q;
        end
        if (req) begin
          tgt_d   = req_tgt;
          state_d = MAN_PEND;
        end else if (vs_rise) begin
          state_d = MAN_IDLE;
        end else begin
          state_d = MAN_PEND;
        end
      end
`ifdef PIXMODE_AUTO_EN
      AUTO: begin
        if (!auto_s2_q) begin
          state_d = MAN_IDLE;
          tgt_d   = mode_q;
        end else if (vs_rise) begin
          if (fcnt_q == FCNT_LAST) begin
            mode_d = mode_q + 2'd1;
            tgt_d  = mode_q + 2'd1;
            fcnt_d = 8'd0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end else begin
          state_d = AUTO;
        end
      end
`endif
      default: begin
        state_d = MAN_IDLE;
        tgt_d   = mode_q;
      end
    endcase
`ifdef PIXMODE_AUTO_EN
    // Auto entry discards any pending request, including one due this vsync.
    if ((state_q != AUTO) && auto_s2_q) begin
      state_d = AUTO;
      tgt_d   = mode_q;
      mode_d  = mode_q;
      fcnt_d  = 8'd0;
    end else begin
      fcnt_d  = fcnt_d;
    end
`endif
    pend_d = (state_d == MAN_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MAN_IDLE;
      tgt_q   <= MODE_RGB;
      mode_q  <= MODE_RGB;
      pend_q  <= 1'b0;
`ifdef PIXMODE_AUTO_EN
      fcnt_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
`ifdef PIXMODE_AUTO_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign out_swt  = {6'b000000, mode_q};
  assign out_mode = mode_q;
  assign out_pend = pend_q;

endmodule

// File: doc/pixmode_seq.md
# pixmode_seq

Frame-synchronous mode sequencer for the pixel select stage. Takes user switches, a raw push-button and an optional auto-cycle request, and drives the 8-bit mode select of the pixel-select datapath. A new mode takes effect only at a vertical-sync rising edge, so a frame is never split between two modes. Sits between the board I/O and the pixel-select stage, on the same pixel clock.

## Interface

Parameters:
- DB_CYCLES, 50000: stable cycles required before a button level is accepted.
- FRAMES_PER_MODE, 60: frames per mode in auto-cycle; legal range 1..255.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- in_c  in  3  video control {vsync, hsync, de}; bit 2 is vsync, active-high; synchronous to clk.
- sw_mode  in  8  raw user mode switches; asynchronous.
- btn_next  in  1  raw push-button, active-high; asynchronous.
- sw_auto  in  1  raw auto-cycle switch; asynchronous.
- out_swt  out  8  applied mode select to the pixel-select stage; always {6'b0, mode}.
- out_mode  out  2  applied mode: 0 RGB, 1 Y, 2 U, 3 V.
- out_pend  out  1  a requested mode is waiting for vsync.

## Operation

- Inputs sw_mode, btn_next and sw_auto each pass through a 2-flop synchroniser. The synchronised button then goes through the debouncer. A press event is a debounced 0->1 transition.
- legalize(x) = x[1:0] if x <= 3, else 0.
- Switch event: the synchronised sw_mode differs from its registered previous value.
- vs_rise = in_c[2] & ~vs_q, where vs_q is in_c[2] registered.
- Registers: tgt[1:0], mode[1:0], frame counter fcnt[7:0], FSM state.
- FSM state MAN_IDLE (out_pend = 0):
  - Switch event -> tgt = legalize(sync sw_mode); go to MAN_PEND.
  - Press event -> tgt = mode+1 mod 4; go to MAN_PEND.
- FSM state MAN_PEND (out_pend = 1):
  - Further events overwrite tgt; last request wins.
  - On vs_rise -> mode = tgt; go to MAN_IDLE.
- FSM state AUTO:
  - Entered from either manual state when the synchronised sw_auto = 1. On entry fcnt = 0, out_pend = 0, pending tgt is discarded.
  - Switch and press events are ignored.
  - On vs_rise: if fcnt == FRAMES_PER_MODE-1, then mode = mode+1 mod 4, tgt = that same value, fcnt = 0. Otherwise fcnt = fcnt+1.
  - On synchronised sw_auto = 0 -> go to MAN_IDLE with tgt = mode.
- Simultaneous switch event and press event in the same cycle: the switch wins and the press is dropped.
- Event in the same cycle as vs_rise while in MAN_PEND: the old tgt is applied, the new tgt is latched, and the state stays MAN_PEND.
- Event in the same cycle as vs_rise while in MAN_IDLE: the state goes to MAN_PEND and the change applies at the next vsync.
- Wrap-around: mode 3 + 1 = 0.

## Timing

- Reset values: out_swt = 0, out_mode = 0, out_pend = 0, tgt = 0, fcnt = 0, state MAN_IDLE. All synchroniser, debouncer and previous-value registers are 0.
- Reset is asynchronous and may assert mid-frame; outputs clear immediately.
- If sw_mode is nonzero at reset release, a switch event fires 3 cycles later.
- Switch path latency: 3 clk edges from the sw_mode change to out_pend = 1.
- Button path latency: 2 + DB_CYCLES + 1 edges from the button change to out_pend = 1.
- Apply latency: out_swt and out_mode update on the clk edge at which in_c[2] = 1 is first sampled; out_pend falls on that same edge.
- out_swt and out_mode are registered and change only on vs_rise edges (or reset).

## Configuration

- PIXMODE_AUTO_EN defined: the AUTO state, fcnt and the sw_auto synchroniser are built.
- PIXMODE_AUTO_EN undefined: sw_auto is ignored, fcnt is not built, and the FSM has only MAN_IDLE and MAN_PEND. FRAMES_PER_MODE is unused.

## Structure

- Shared package pixmode_pkg holds:
  - mode constants MODE_RGB = 0, MODE_Y = 1, MODE_U = 2, MODE_V = 3;
  - the FSM state encoding;
  - the legalize function.
- Sub-module btn_debounce:
  - takes a synchronised level and produces a debounced level plus a one-cycle rise pulse;
  - parameter DB_CYCLES;
  - counter width is the clog2 of DB_CYCLES.
- Top-level total: 150-250 lines.

## Test plan

- Reset with sw_mode = 0, then set sw_mode = 2 mid-frame -> out_pend = 1 after 3 edges; out_swt = 2 at the next vsync rise; out_pend = 0.
- sw_mode = 9 -> mode 0 is requested; at vsync out_swt = 0.
- DB_CYCLES = 4, mode 3; a bouncing btn_next (pulses shorter than 4 cycles) then a stable press -> exactly one event; at vsync out_mode = 0 (wrap-around).
- Switch change and press in the same cycle, sw_mode = 1, mode 0 -> out_mode = 1 after vsync, not 2; three switch changes 1, 2, 3 within one frame -> only 3 is applied.
- PIXMODE_AUTO_EN, FRAMES_PER_MODE = 2, sw_auto = 1, 8 vsync rises -> out_mode sequence 0, 1, 1, 2, 2, 3, 3, 0; sw_mode toggles are ignored.
- Assert rst in MAN_PEND mid-frame -> all outputs 0 immediately; the next vsync leaves out_swt = 0.
